mfp_ahb_lite_slave_pipe: RTL and testbench

Parametrised AHB-Lite slave front end for on-chip memories and peripheral register files; successor to the fixed 32-bit, fixed-latency slave adapter.
Generalises data width, address width and memory read latency. Adds a real HREADYOUT/HREADY pipeline, a two-cycle ERROR response for illegal transfers, and read-after-write stall with reissue.
Sits between the AHB-Lite interconnect (decoder/mux) and a simple synchronous memory port with byte-lane write mask.

---
 rtl/mfp_ahb_lite_slave_pipe_pkg.sv | 37 +++
 rtl/mfp_ahb_lite_byte_mask.sv | 40 ++++
 rtl/mfp_ahb_lite_slave_pipe.sv | 171 +++++++++++++++++
 tb/tb_mfp_ahb_lite_slave_pipe.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_ahb_lite_slave_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mfp_ahb_lite_slave_pipe_pkg
//   Shared AHB-Lite encodings (HTRANS, HSIZE, HRESP) and the state type of the
//   pipelined AHB-Lite memory slave. Imported by the slave and reusable by
//   other AHB-Lite slaves.
// ---------------------------------------------------------------------------
package mfp_ahb_lite_slave_pipe_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HSIZE encodings (bytes per transfer = 2**HSIZE)
  localparam logic [2:0] HSIZE_1  = 3'b000;
  localparam logic [2:0] HSIZE_2  = 3'b001;
  localparam logic [2:0] HSIZE_4  = 3'b010;
  localparam logic [2:0] HSIZE_8  = 3'b011;
  localparam logic [2:0] HSIZE_16 = 3'b100;
  localparam logic [2:0] HSIZE_32 = 3'b101;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Data-phase state of the slave
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,  // no data phase pending, ready
    ST_WRITE     = 3'd1,  // write data phase, memory write strobe active
    ST_READ_WAIT = 3'd2,  // read data phase, waiting on memory latency
    ST_RAW_STALL = 3'd3,  // read hit a same-word write; read reissued here
    ST_ERR1      = 3'd4,  // first ERROR cycle (not ready)
    ST_ERR2      = 3'd5   // second ERROR cycle (ready)
  } state_e;

endpackage

// File: rtl/mfp_ahb_lite_byte_mask.sv
// ---------------------------------------------------------------------------
// mfp_ahb_lite_byte_mask
//   Converts an AHB transfer size and the low address bits into a byte-lane
//   enable mask for a DATA_WIDTH-bit bus, and flags illegal transfers (size
//   wider than the bus, or address not aligned to the size).
// Ports:
//   hsize_i    AHB HSIZE
//   addr_lo_i  HADDR bits below the bus-word boundary
//   mask_o     byte-lane enables (all zero when illegal)
//   illegal_o  transfer cannot be serviced by this bus width
// ---------------------------------------------------------------------------
module mfp_ahb_lite_byte_mask #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]                        hsize_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   addr_lo_i,
  output logic [DATA_WIDTH/8-1:0]           mask_o,
  output logic                              illegal_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int B  = $clog2(NB);

  // Low address bits that must be zero for an aligned transfer of this size.
  logic [B-1:0] align_bits;
  logic         too_big;

  assign too_big    = hsize_i > 3'(B);
  assign align_bits = ~({B{1'b1}} << hsize_i);
  assign illegal_o  = too_big | ((addr_lo_i & align_bits) != '0);

  // A lane is enabled when it lies in the same size-aligned chunk as the
  // address, i.e. its index matches the address above the alignment bits.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [B-1:0] lane_idx;
    assign lane_idx   = B'(gi);
    assign mask_o[gi] = ~illegal_o & (((lane_idx ^ addr_lo_i) & ~align_bits) == '0);
  end

endmodule

// File: rtl/mfp_ahb_lite_slave_pipe.sv
// ---------------------------------------------------------------------------
// mfp_ahb_lite_slave_pipe
//   Pipelined AHB-Lite slave front end for a synchronous memory with a
//   byte-masked write port and a fixed read latency.
//   - writes: zero wait states, memory write issued in the data phase
//   - reads:  memory read issued in the address phase, READ_LATENCY-1 waits
//   - a read to the word being written in the same cycle is stalled one
//     cycle and reissued, so it returns the newly written data
//   - illegal size/alignment: two-cycle ERROR response, no memory access
// Ports:
//   HCLK, HRESETn                      clock, asynchronous active-low reset
//   HADDR/HSIZE/HTRANS/HWRITE/HSEL     AHB address phase
//   HREADY, HWDATA                     bus ready, write data (data phase)
//   HREADYOUT, HRESP, HRDATA           slave response
//   mem_read_*                         memory read port
//   mem_write_*                        memory write port with byte mask
// ---------------------------------------------------------------------------
module mfp_ahb_lite_slave_pipe
  import mfp_ahb_lite_slave_pipe_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [31:0]             HADDR,
  input  logic [2:0]              HSIZE,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic                    HSEL,
  input  logic                    HREADY,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    mem_read_enable,
  output logic [ADDR_WIDTH-1:0]   mem_read_addr,
  input  logic [DATA_WIDTH-1:0]   mem_read_data,
  output logic                    mem_write_enable,
  output logic [ADDR_WIDTH-1:0]   mem_write_addr,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic [DATA_WIDTH/8-1:0] mem_write_mask
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int B     = $clog2(NB);
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(READ_LATENCY - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NB-1:0]         mask_q, mask_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic [NB-1:0]         cur_mask;
  logic                  cur_illegal;
  logic                  can_accept;
  logic                  accept;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign word_addr = HADDR[ADDR_WIDTH+B-1:B];

  if (ADDR_WIDTH + B < 32) begin : g_unused_haddr
    logic unused_haddr;
    assign unused_haddr = ^HADDR[31:ADDR_WIDTH+B];
  end

  mfp_ahb_lite_byte_mask #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_byte_mask (
    .hsize_i   (HSIZE),
    .addr_lo_i (HADDR[B-1:0]),
    .mask_o    (cur_mask),
    .illegal_o (cur_illegal)
  );

  // Only states that drive HREADYOUT high can take a new address phase;
  // this also keeps a misbehaving HREADY from breaking a stall.
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_WRITE) ||
                      (state_q == ST_ERR2);
  assign accept     = can_accept & HSEL & HREADY &
                      ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    rd_addr = word_addr;

    case (state_q)
      ST_READ_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      end

      ST_RAW_STALL: begin
        // The colliding write has landed; reissue the saved read.
        rd_en   = 1'b1;
        rd_addr = addr_q;
        if (READ_LATENCY > 1) begin
          state_d = ST_READ_WAIT;
          cnt_d   = LAT_M1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ERR1: state_d = ST_ERR2;

      default: begin  // ST_IDLE, ST_WRITE, ST_ERR2: last data-phase cycle
        state_d = ST_IDLE;
        if (accept) begin
          if (cur_illegal) begin
            state_d = ST_ERR1;
          end else if (HWRITE) begin
            state_d = ST_WRITE;
            addr_d  = word_addr;
            mask_d  = cur_mask;
          end else if ((state_q == ST_WRITE) && (word_addr == addr_q)) begin
            // Same word is being written this cycle: the memory would return
            // stale data, so hold the read back by one cycle.
            state_d = ST_RAW_STALL;
            addr_d  = word_addr;
          end else begin
            rd_en  = 1'b1;
            addr_d = word_addr;
            if (READ_LATENCY > 1) begin
              state_d = ST_READ_WAIT;
              cnt_d   = LAT_M1;
            end
          end
        end
      end
    endcase
  end

  // Strobes are gated with reset so they drop the moment reset asserts,
  // even though the read strobe is decoded from live address-phase inputs.
  assign mem_read_enable  = rd_en & HRESETn;
  assign mem_read_addr    = rd_addr;
  assign mem_write_enable = (state_q == ST_WRITE);
  assign mem_write_addr   = addr_q;
  assign mem_write_mask   = (state_q == ST_WRITE) ? mask_q : '0;
  assign mem_write_data   = HWDATA;
  assign HRDATA           = mem_read_data;

  assign HREADYOUT = !((state_q == ST_ERR1) || (state_q == ST_READ_WAIT) ||
                       (state_q == ST_RAW_STALL));
  assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR
                                                                    : HRESP_OKAY;

endmodule

// File: tb/tb_mfp_ahb_lite_slave_pipe.sv
// ---------------------------------------------------------------------------
// tb_mfp_ahb_lite_slave_pipe
//   Two slave instances share the AHB address/data inputs: index 0 has
//   READ_LATENCY=1, index 1 has READ_LATENCY=3. HSEL picks the target. Each
//   has its own memory model; a byte-level reference memory per instance
//   holds the contents expected from the bus-level transfers.
// ---------------------------------------------------------------------------
module tb_mfp_ahb_lite_slave_pipe;

  localparam int DW = 32;
  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        init_req;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [1:0]  hsel;
  logic [DW-1:0] hwdata;

  logic [1:0]    rdy, resp, re, we;
  logic [DW-1:0] rdata [2];
  logic [AW-1:0] ra [2];
  logic [AW-1:0] wa [2];
  logic [DW-1:0] mrd [2];
  logic [DW-1:0] wd [2];
  logic [3:0]    wm [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_b [2][256];

  function automatic logic [31:0] init_word(input int g, input int w);
    return (32'h9E3779B9 * 32'(w + 1)) ^ 32'(g * 32'h01020304);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;
    logic [DW-1:0] mem  [64];
    logic [DW-1:0] pipe [4];

    mfp_ahb_lite_slave_pipe #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .READ_LATENCY (LAT)
    ) u_dut (
      .HCLK             (clk),
      .HRESETn          (rst_n),
      .HADDR            (haddr),
      .HSIZE            (hsize),
      .HTRANS           (htrans),
      .HWRITE           (hwrite),
      .HSEL             (hsel[gi]),
      .HREADY           (rdy[gi]),
      .HWDATA           (hwdata),
      .HREADYOUT        (rdy[gi]),
      .HRESP            (resp[gi]),
      .HRDATA           (rdata[gi]),
      .mem_read_enable  (re[gi]),
      .mem_read_addr    (ra[gi]),
      .mem_read_data    (mrd[gi]),
      .mem_write_enable (we[gi]),
      .mem_write_addr   (wa[gi]),
      .mem_write_data   (wd[gi]),
      .mem_write_mask   (wm[gi])
    );

    // Synchronous memory with byte-masked write and LAT-cycle read pipeline.
    always @(posedge clk) begin
      if (init_req) begin
        for (int w = 0; w < 64; w++) mem[w] <= init_word(gi, w);
      end else if (we[gi]) begin
        for (int b = 0; b < 4; b++)
          if (wm[gi][b]) mem[wa[gi][5:0]][8*b +: 8] <= wd[gi][8*b +: 8];
      end
      if (re[gi]) pipe[0] <= mem[ra[gi][5:0]];
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign mrd[gi] = pipe[LAT-1];
  end

  // ---------------- reference model ----------------
  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [31:0] addr, input int size);
    logic [3:0] m;
    int lo;
    int n;
    m  = '0;
    lo = int'(addr % 4);
    n  = 1 << size;
    for (int b = 0; b < 4; b++) if (b >= lo && b < lo + n) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] ref_word(input int s, input logic [31:0] addr);
    int base;
    base = int'(addr & 32'hFC);
    return {ref_b[s][base+3], ref_b[s][base+2], ref_b[s][base+1], ref_b[s][base]};
  endfunction

  task automatic ref_store(input int s, input logic [31:0] addr, input int size,
                           input logic [31:0] data);
    logic [3:0] m;
    int base;
    m    = exp_mask(addr, size);
    base = int'(addr & 32'hFC);
    for (int b = 0; b < 4; b++) if (m[b]) ref_b[s][base+b] = data[8*b +: 8];
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_addr(input int s, input logic wr, input logic [31:0] a, input int size);
    hsel    = '0;
    hsel[s] = 1'b1;
    htrans  = 2'b10;
    hwrite  = wr;
    haddr   = a;
    hsize   = 3'(size);
  endtask

  task automatic drive_idle();
    hsel   = '0;
    htrans = 2'b00;
    hwrite = 1'b0;
    haddr  = '0;
    hsize  = '0;
  endtask

  task automatic wait_data(input int s, input logic [31:0] addr, input int expw,
                           input int w0);
    int w;
    w = w0;
    @(negedge clk);
    while (rdy[s] !== 1'b1 && w < 32) begin
      w++;
      step();
      @(negedge clk);
    end
    chk("rd_waits", 64'(w), 64'(expw));
    chk("rd_data", rdata[s], ref_word(s, addr));
    chk("rd_resp", resp[s], 0);
    step();
  endtask

  task automatic do_write(input int s, input logic [31:0] addr, input int size,
                          input logic [31:0] data);
    $display("txn WR dut=%0d addr=0x%02h size=%0d data=0x%08h", s, addr, size, data);
    drive_addr(s, 1'b1, addr, size);
    @(negedge clk);
    chk("wr_aphase_ready", rdy[s], 1);
    step();
    drive_idle();
    hwdata = data;
    @(negedge clk);
    chk("wr_we", we[s], 1);
    chk("wr_addr", wa[s], addr >> 2);
    chk("wr_mask", wm[s], exp_mask(addr, size));
    chk("wr_ready", rdy[s], 1);
    chk("wr_resp", resp[s], 0);
    ref_store(s, addr, size, data);
    step();
  endtask

  task automatic do_read(input int s, input logic [31:0] addr, input int size);
    $display("txn RD dut=%0d addr=0x%02h size=%0d", s, addr, size);
    drive_addr(s, 1'b0, addr, size);
    @(negedge clk);
    chk("rd_re", re[s], 1);
    chk("rd_addr", ra[s], addr >> 2);
    step();
    drive_idle();
    wait_data(s, addr, lat_of(s) - 1, 0);
  endtask

  // Word write immediately followed by a word read in the write's data phase.
  task automatic do_wr_rd(input int s, input logic [31:0] waddr, input logic [31:0] wdata,
                          input logic [31:0] raddr);
    logic hit;
    hit = (waddr >> 2) == (raddr >> 2);
    $display("txn WR->RD dut=%0d waddr=0x%02h raddr=0x%02h data=0x%08h", s, waddr, raddr, wdata);
    drive_addr(s, 1'b1, waddr, 2);
    step();
    hwdata = wdata;
    drive_addr(s, 1'b0, raddr, 2);
    @(negedge clk);
    chk("wrrd_we", we[s], 1);
    chk("wrrd_waddr", wa[s], waddr >> 2);
    chk("wrrd_mask", wm[s], 4'hF);
    chk("wrrd_ready", rdy[s], 1);
    chk("wrrd_re", re[s], !hit);
    if (!hit) chk("wrrd_raddr", ra[s], raddr >> 2);
    ref_store(s, waddr, 2, wdata);
    step();
    drive_idle();
    if (hit) begin
      @(negedge clk);
      chk("raw_stall_ready", rdy[s], 0);
      chk("raw_reissue_re", re[s], 1);
      chk("raw_reissue_addr", ra[s], raddr >> 2);
      chk("raw_stall_we", we[s], 0);
      step();
      wait_data(s, raddr, lat_of(s), 1);
    end else begin
      wait_data(s, raddr, lat_of(s) - 1, 0);
    end
  endtask

  // Illegal transfer, a read presented during ERR1, then a legal word write
  // accepted during ERR2.
  task automatic do_err(input int s, input logic [31:0] addr, input int size, input logic wr,
                        input logic [31:0] naddr, input logic [31:0] ndata);
    $display("txn ERR dut=%0d addr=0x%02h size=%0d write=%0d then WR 0x%02h", s, addr, size, wr, naddr);
    drive_addr(s, wr, addr, size);
    @(negedge clk);
    chk("err_aphase_re", re[s], 0);
    step();
    hwdata = $urandom;
    drive_addr(s, 1'b0, naddr, 2);
    @(negedge clk);
    chk("err1_ready", rdy[s], 0);
    chk("err1_resp", resp[s], 1);
    chk("err1_we", we[s], 0);
    chk("err1_re", re[s], 0);
    step();
    drive_addr(s, 1'b1, naddr, 2);
    @(negedge clk);
    chk("err2_ready", rdy[s], 1);
    chk("err2_resp", resp[s], 1);
    chk("err2_we", we[s], 0);
    step();
    drive_idle();
    hwdata = ndata;
    @(negedge clk);
    chk("after_err_we", we[s], 1);
    chk("after_err_addr", wa[s], naddr >> 2);
    chk("after_err_mask", wm[s], 4'hF);
    chk("after_err_resp", resp[s], 0);
    chk("after_err_ready", rdy[s], 1);
    ref_store(s, naddr, 2, ndata);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, a2, d;
    int s, op, sz;

    rst_n    = 1'b0;
    init_req = 1'b1;
    hwdata   = '0;
    drive_idle();
    for (int g = 0; g < 2; g++)
      for (int w = 0; w < 64; w++) begin
        d = init_word(g, w);
        for (int b = 0; b < 4; b++) ref_b[g][4*w+b] = d[8*b +: 8];
      end

    // Reset state
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("reset_ready", rdy[g], 1);
      chk("reset_resp", resp[g], 0);
      chk("reset_we", we[g], 0);
      chk("reset_re", re[g], 0);
      chk("reset_mask", wm[g], 0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    init_req = 1'b0;
    rst_n    = 1'b1;
    step();

    // Directed: word write/read, byte and halfword lanes
    do_write(0, 32'h10, 2, 32'h11223344);
    do_read(0, 32'h10, 2);
    do_write(0, 32'h13, 0, 32'hAB000000);
    do_write(0, 32'h12, 1, 32'hCDEF0000);
    do_read(0, 32'h10, 2);
    do_write(0, 32'h15, 0, 32'h0000_5A00);

    // Read-after-write: same word stalls, neighbouring word does not
    do_wr_rd(0, 32'h20, 32'hCAFEF00D, 32'h20);
    do_wr_rd(0, 32'h20, 32'h0BADBEEF, 32'h24);

    // Latency 3
    do_read(1, 32'h10, 2);
    do_wr_rd(1, 32'h30, 32'h12345678, 32'h30);

    // Illegal transfers
    do_err(0, 32'h01, 1, 1'b0, 32'h34, 32'hA5A5A5A5);
    do_err(0, 32'h40, 3, 1'b1, 32'h44, 32'h5A5A5A5A);
    do_read(0, 32'h34, 2);
    do_read(0, 32'h40, 2);

    // Reset during READ_WAIT (latency-3 instance)
    $display("txn RESET during read wait dut=1");
    drive_addr(1, 1'b0, 32'h50, 2);
    step();
    drive_idle();
    @(negedge clk);
    chk("rstrd_pre_ready", rdy[1], 0);
    #2;
    drive_addr(1, 1'b0, 32'h54, 2);
    rst_n = 1'b0;
    #1;
    chk("rstrd_ready", rdy[1], 1);
    chk("rstrd_resp", resp[1], 0);
    chk("rstrd_re", re[1], 0);
    chk("rstrd_we", we[1], 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_idle();
    step();
    do_read(1, 32'h50, 2);

    // Reset during write data phase: write must be discarded
    $display("txn RESET during write data phase dut=0");
    drive_addr(0, 1'b1, 32'h60, 2);
    step();
    drive_idle();
    hwdata = 32'hFFFF0000;
    @(negedge clk);
    chk("rstwr_pre_we", we[0], 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstwr_we", we[0], 0);
    chk("rstwr_mask", wm[0], 0);
    chk("rstwr_ready", rdy[0], 1);
    chk("rstwr_resp", resp[0], 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    do_read(0, 32'h60, 2);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      s  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 5));
      sz = int'($urandom_range(0, 2));
      a  = $urandom_range(0, 255);
      a  = a & ~((32'd1 << sz) - 1);
      d  = $urandom;
      case (op)
        0, 1: do_write(s, a, sz, d);
        2, 3: do_read(s, a, sz);
        4: begin
          a  = a & 32'hFC;
          a2 = ($urandom_range(0, 1) == 1) ? a : (($urandom_range(0, 255)) & 32'hFC);
          do_wr_rd(s, a, d, a2);
        end
        default: begin
          a2 = $urandom_range(0, 255) & 32'hFC;
          if ($urandom_range(0, 1) == 1) do_err(s, a | 32'h1, int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)), a2, d);
          else                           do_err(s, a, 3, 1'($urandom_range(0, 1)), a2, d);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
